// File: rtl/input_conditioner.sv
// Synchronises and debounces slide switches and active-low push buttons, emitting clean
// active-high levels plus one-cycle press/release/change pulses; fully registered outputs.
module input_conditioner #(
  parameter int N_SW            = 10,
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             CLK1,
  input  logic             RST_N,
  input  logic [N_SW-1:0]  SW_IN,
  input  logic [N_BTN-1:0] BTN_IN,
  output logic [N_SW-1:0]  SW_OUT,
  output logic [N_BTN-1:0] BTN_LVL,
  output logic [N_BTN-1:0] BTN_PRESS,
  output logic [N_BTN-1:0] BTN_RELEASE,
  output logic             SW_CHG
);

  localparam int N  = N_SW + N_BTN;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Buttons sit in the upper bits; their sync flops idle at 1 (released) and get inverted.
  localparam logic [N-1:0] BTN_MASK = {{N_BTN{1'b1}}, {N_SW{1'b0}}};

  logic [N-1:0]  sync1, sync2, stable, stable_nxt, cond;
  logic [CW-1:0] cnt     [N];
  logic [CW-1:0] cnt_nxt [N];
  logic          sw_chg_q;
  logic [N_BTN-1:0] press_q, release_q;

  assign cond = sync2 ^ BTN_MASK;

  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < N; i++) begin
      cnt_nxt[i] = cnt[i];
      if (cond[i] == stable[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_LAST) begin
        stable_nxt[i] = cond[i];
        cnt_nxt[i]    = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge CLK1) begin
    if (!RST_N) begin
      sync1     <= BTN_MASK;
      sync2     <= BTN_MASK;
      stable    <= '0;
      sw_chg_q  <= 1'b0;
      press_q   <= '0;
      release_q <= '0;
      for (int i = 0; i < N; i++) cnt[i] <= '0;
    end else begin
      sync1     <= {BTN_IN, SW_IN};
      sync2     <= sync1;
      stable    <= stable_nxt;
      sw_chg_q  <= |(stable_nxt[N_SW-1:0] ^ stable[N_SW-1:0]);
      press_q   <= stable_nxt[N-1:N_SW] & ~stable[N-1:N_SW];
      release_q <= ~stable_nxt[N-1:N_SW] & stable[N-1:N_SW];
      for (int i = 0; i < N; i++) cnt[i] <= cnt_nxt[i];
    end
  end

  assign SW_OUT      = stable[N_SW-1:0];
  assign BTN_LVL     = stable[N-1:N_SW];
  assign BTN_PRESS   = press_q;
  assign BTN_RELEASE = release_q;
  assign SW_CHG      = sw_chg_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES=4 (acceptance on edge E6).
module tb_input_conditioner;

  logic       CLK1 = 1'b0;
  logic       RST_N;
  logic [9:0] SW_IN;
  logic [1:0] BTN_IN;
  logic [9:0] SW_OUT;
  logic [1:0] BTN_LVL, BTN_PRESS, BTN_RELEASE;
  logic       SW_CHG;

  int n_chk  = 0;
  int n_pass = 0;

  input_conditioner #(.N_SW(10), .N_BTN(2), .DEBOUNCE_CYCLES(4)) dut (
    .CLK1(CLK1), .RST_N(RST_N), .SW_IN(SW_IN), .BTN_IN(BTN_IN),
    .SW_OUT(SW_OUT), .BTN_LVL(BTN_LVL), .BTN_PRESS(BTN_PRESS),
    .BTN_RELEASE(BTN_RELEASE), .SW_CHG(SW_CHG)
  );

  always #10 CLK1 = ~CLK1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge CLK1);
    #1;
  endtask

  // Inputs were just changed; expect nothing through E5, the new levels and pulses at E6,
  // and pulses gone again at E7.
  task automatic run_accept(input string tag, input logic [9:0] sw_exp, input logic [1:0] lvl_exp,
                            input logic chg_exp, input logic [1:0] prs_exp, input logic [1:0] rel_exp);
    logic [9:0] sw0;
    logic [1:0] lvl0;
    logic       early;
    sw0   = SW_OUT;
    lvl0  = BTN_LVL;
    early = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (SW_OUT !== sw0 || BTN_LVL !== lvl0 || SW_CHG !== 1'b0 ||
          BTN_PRESS !== 2'b00 || BTN_RELEASE !== 2'b00) early = 1'b1;
    end
    chk({tag, "_early"}, 32'(early), 32'd0);
    tick();
    chk({tag, "_sw"},  32'(SW_OUT),      32'(sw_exp));
    chk({tag, "_lvl"}, 32'(BTN_LVL),     32'(lvl_exp));
    chk({tag, "_chg"}, 32'(SW_CHG),      32'(chg_exp));
    chk({tag, "_prs"}, 32'(BTN_PRESS),   32'(prs_exp));
    chk({tag, "_rel"}, 32'(BTN_RELEASE), 32'(rel_exp));
    tick();
    chk({tag, "_pulse_off"}, 32'({SW_CHG, BTN_PRESS, BTN_RELEASE}), 32'd0);
    chk({tag, "_hold"}, 32'({SW_OUT, BTN_LVL}), 32'({sw_exp, lvl_exp}));
  endtask

  initial begin
    logic bad;
    // 1: reset with switches high and both buttons pressed
    RST_N  = 1'b0;
    SW_IN  = 10'h3FF;
    BTN_IN = 2'b00;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if ({SW_OUT, BTN_LVL, SW_CHG, BTN_PRESS, BTN_RELEASE} !== '0) bad = 1'b1;
    end
    chk("reset_outputs", 32'(bad), 32'd0);
    RST_N = 1'b1;
    run_accept("rst_rel", 10'h3FF, 2'b11, 1'b1, 2'b11, 2'b00);

    // Back to all-zero switches and released buttons, accepted together
    SW_IN  = 10'h000;
    BTN_IN = 2'b11;
    run_accept("clr", 10'h000, 2'b00, 1'b1, 2'b00, 2'b11);

    // 2: multi-bit switch patterns
    SW_IN = 10'h035;
    run_accept("sw035", 10'h035, 2'b00, 1'b1, 2'b00, 2'b00);
    SW_IN = 10'h04A;
    run_accept("sw04a", 10'h04A, 2'b00, 1'b1, 2'b00, 2'b00);

    // 3: 3-cycle glitch on button 0 is rejected
    BTN_IN = 2'b10;
    tick(); tick(); tick();
    BTN_IN = 2'b11;
    bad = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (BTN_LVL !== 2'b00 || BTN_PRESS !== 2'b00 || BTN_RELEASE !== 2'b00) bad = 1'b1;
    end
    chk("glitch_reject", 32'(bad), 32'd0);

    // 4: button 1 held 10 cycles, then released
    BTN_IN = 2'b01;
    run_accept("b1_press", 10'h04A, 2'b10, 1'b0, 2'b10, 2'b00);
    tick(); tick(); tick();
    BTN_IN = 2'b11;
    run_accept("b1_release", 10'h04A, 2'b00, 1'b0, 2'b00, 2'b10);

    // 5: reset mid-debounce restarts the full acceptance window
    SW_IN = 10'h000;
    run_accept("sw000", 10'h000, 2'b00, 1'b1, 2'b00, 2'b00);
    SW_IN = 10'h07F;
    bad = 1'b0;
    tick(); tick();
    RST_N = 1'b0;
    tick();
    if (SW_OUT !== 10'h000 || SW_CHG !== 1'b0) bad = 1'b1;
    RST_N = 1'b1;
    chk("midrst_hold", 32'(bad), 32'd0);
    run_accept("midrst_acc", 10'h07F, 2'b00, 1'b1, 2'b00, 2'b00);

    // 6: switch and button changes accepted in parallel
    SW_IN = 10'h000;
    run_accept("sw000b", 10'h000, 2'b00, 1'b1, 2'b00, 2'b00);
    SW_IN  = 10'h07F;
    BTN_IN = 2'b10;
    run_accept("parallel", 10'h07F, 2'b01, 1'b1, 2'b01, 2'b00);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
